// File: rtl/serial_magnitude_comparator_if.sv
// Producer/consumer handshake bundle for the serial magnitude comparator.
// The slave modport is the comparator's view; the master modport is the producer/consumer side.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2,
    parameter int CW    = $clog2(WIDTH / DIGIT + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             less_than;
    logic             equal_to;
    logic             greater_than;
    logic [CW-1:0]    cycles;

    modport slave (
        input  in_valid,
        input  a_in,
        input  b_in,
        input  signed_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output less_than,
        output equal_to,
        output greater_than,
        output cycles
    );

    modport master (
        output in_valid,
        output a_in,
        output b_in,
        output signed_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  less_than,
        input  equal_to,
        input  greater_than,
        input  cycles
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator with early exit and valid/ready on both sides.
// Signed operands are mapped to offset binary at capture so the digit compare is always unsigned.

module serial_magnitude_comparator_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_in_ready,
    input logic i_out_valid,
    input logic i_lt,
    input logic i_eq,
    input logic i_gt
);
    a_result_onehot : assert property (@(posedge i_clk) disable iff (i_reset)
        i_out_valid |-> $onehot({i_lt, i_eq, i_gt}));

    a_flags_quiet : assert property (@(posedge i_clk) disable iff (i_reset)
        !i_out_valid |-> ({i_lt, i_eq, i_gt} == 3'b000));

    a_ready_valid_excl : assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_in_ready && i_out_valid));
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input logic                          i_clk,
    input logic                          i_reset,
    serial_magnitude_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Returns {a<b, a>b}; both zero means the digits match.
    function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] a, input logic [DIGIT-1:0] b);
        return {(a < b), (a > b)};
    endfunction

    function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] op, input logic is_signed);
        return op ^ {is_signed, {(WIDTH-1){1'b0}}};
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] w_sa_nxt;
    logic [WIDTH-1:0] w_sb_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic             w_lt_nxt;
    logic             w_eq_nxt;
    logic             w_gt_nxt;
    logic [CW-1:0]    r_cycles;
    logic [CW-1:0]    w_cycles_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       w_top_cmp;

    assign w_top_cmp = digit_cmp(r_sa[WIDTH-1 -: DIGIT], r_sb[WIDTH-1 -: DIGIT]);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt  = r_state;
        w_sa_nxt     = r_sa;
        w_sb_nxt     = r_sb;
        w_cnt_nxt    = r_cnt;
        w_lt_nxt     = r_lt;
        w_eq_nxt     = r_eq;
        w_gt_nxt     = r_gt;
        w_cycles_nxt = r_cycles;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_sa_nxt    = to_offset(bus.a_in, bus.signed_mode);
                    w_sb_nxt    = to_offset(bus.b_in, bus.signed_mode);
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_top_cmp != 2'b00) begin
                    w_lt_nxt     = w_top_cmp[1];
                    w_gt_nxt     = w_top_cmp[0];
                    w_eq_nxt     = 1'b0;
                    w_cycles_nxt = r_cnt + CW'(1);
                    w_state_nxt  = S_DONE;
                end else if (r_cnt == CW'(NDIG - 1)) begin
                    w_lt_nxt     = 1'b0;
                    w_gt_nxt     = 1'b0;
                    w_eq_nxt     = 1'b1;
                    w_cycles_nxt = CW'(NDIG);
                    w_state_nxt  = S_DONE;
                end else begin
                    w_sa_nxt    = r_sa << DIGIT;
                    w_sb_nxt    = r_sb << DIGIT;
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_lt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_lt_nxt    = 1'b0;
                w_eq_nxt    = 1'b0;
                w_gt_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and handshake registers; ready/valid are decoded from the next state so they are registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sa        <= {WIDTH{1'b0}};
            r_sb        <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_cycles    <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_sa        <= w_sa_nxt;
            r_sb        <= w_sb_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lt        <= w_lt_nxt;
            r_eq        <= w_eq_nxt;
            r_gt        <= w_gt_nxt;
            r_cycles    <= w_cycles_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.less_than    = r_lt;
    assign bus.equal_to     = r_eq;
    assign bus.greater_than = r_gt;
    assign bus.cycles       = r_cycles;

    serial_magnitude_comparator_chk u_chk (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_ready  (r_in_ready),
        .i_out_valid (r_out_valid),
        .i_lt        (r_lt),
        .i_eq        (r_eq),
        .i_gt        (r_gt)
    );
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Next-generation serialized comparator. Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode.
- Terminates early at the first differing digit.
- Input and output use valid/ready handshakes, so the block sits in a streaming datapath between a producer and a result consumer.
- Reports a one-hot lt/eq/gt result plus the number of digit cycles used.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 2.
- DIGIT, 2, bits examined per RUN cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.
- CW, $clog2(NDIG+1), width of cycles output (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operand pair.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts the result.
- less_than  output  1  A < B.
- equal_to  output  1  A == B.
- greater_than  output  1  A > B.
- cycles  output  CW  RUN cycles used for this result (1..NDIG).

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, in_ready=1, out_valid=0, less_than/equal_to/greater_than=0, cycles=0, internal shift registers and counter cleared. A reset mid-RUN or in DONE discards the transaction; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a_in/b_in into shift registers. If signed_mode, invert bit WIDTH-1 of both captured operands (offset-binary mapping, so unsigned digit compare is correct).
  - Set digit counter=0 and go to RUN.
- RUN (in_ready=0, out_valid=0):
  - Each cycle, compare the top DIGIT bits of sa and sb as unsigned values, then increment the counter.
  - If sa_top≠sb_top: latch lt=(sa_top<sb_top), gt=(sa_top>sb_top), eq=0, cycles=counter+1, go to DONE.
  - Else if counter==NDIG-1: latch eq=1, lt=gt=0, cycles=NDIG, go to DONE.
  - Else: shift sa and sb left by DIGIT and stay in RUN.
- DONE:
  - out_valid=1; exactly one of lt/eq/gt is 1; outputs stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0, result flags cleared to 0.
  - in_ready stays 0 in DONE, giving one bubble cycle between transactions.
- Latency:
  - Accept at edge T; the first digit compare happens in the cycle after T.
  - out_valid rises at edge T+k, where k = index (1-based) of the first differing digit, or NDIG if the operands are equal.
  - Best case is 1 RUN cycle; worst case is NDIG.
- Invariants: out_valid implies one-hot(lt, eq, gt); out_valid=0 implies all three flags are 0; in_ready and out_valid are never both 1.
- Inputs a_in/b_in/signed_mode are ignored outside an IDLE handshake; changes during RUN have no effect.
- in_valid held high in DONE is not accepted until after the return to IDLE.

Test Plan (WIDTH=16, DIGIT=2, NDIG=8):
- Reset mid-RUN: a=0x0000, b=0x0001, assert reset at RUN cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0, all flags 0; no result ever emitted.
- Unsigned early exit: a=0x8000, b=0x7FFF, signed_mode=0 -> greater_than=1, cycles=1, out_valid 1 cycle after accept.
- Signed mode: same operands, signed_mode=1 -> less_than=1, cycles=1. Also a=0xFFFF (-1), b=0x0001, signed -> less_than=1.
- Mid-word difference: a=0x1200, b=0x1300, unsigned -> less_than=1, cycles=4.
- Equal and worst-case latency: a=b=0x1234 -> equal_to=1, cycles=8, out_valid 8 cycles after accept.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> flags and cycles stable, in_ready=0 throughout.
  - Then pulse out_ready with in_valid high -> IDLE for 1 cycle, next pair accepted.
